// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine coin feeder.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFeed  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Coin tokens as {coin_i, coin_j}
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b10;
  localparam logic [1:0] COIN_TWO  = 2'b11;

  localparam int unsigned AMT_W_DEF     = 6;
  localparam int unsigned CNT_W_DEF     = 4;
  localparam int unsigned DRAIN_CYC_DEF = 2;

endpackage

// File: rtl/vend_coin_feeder_if.sv
// Request handshake, coin-token and machine-response signals of the coin feeder.
interface vend_coin_feeder_if
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W = AMT_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             coin_i;
  logic             coin_j;
  logic             vend_x;
  logic             vend_y;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] product_count;
  logic [CNT_W-1:0] change_count;

  // Payment front-end / machine side
  modport master (
    output req_valid, req_amount, vend_x, vend_y,
    input  req_ready, coin_i, coin_j, busy, done, product_count, change_count
  );

  // Feeder side
  modport slave (
    input  req_valid, req_amount, vend_x, vend_y,
    output req_ready, coin_i, coin_j, busy, done, product_count, change_count
  );

endinterface

// File: rtl/vend_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module vend_sat_counter
  import vend_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != CntMax)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vend_coin_feeder.sv
// Pays a requested amount as one contiguous burst of 2/1-rupee coins, then counts
// the machine's dispense and change pulses until the response has drained.
module vend_coin_feeder
  import vend_pkg::*;
#(
  parameter int unsigned AMT_W     = AMT_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF
) (
  input logic               clock,
  input logic               reset,
  vend_coin_feeder_if.slave bus
);

  localparam int unsigned DrW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [DrW-1:0]   drain_q, drain_d;
  logic             coin_two;
  logic [AMT_W-1:0] step;
  logic             accept;
  logic             counting;

  assign coin_two = remaining_q >= AMT_W'(2);
  assign step     = coin_two ? AMT_W'(2) : AMT_W'(1);
  assign accept   = (state_q == StIdle) && bus.req_valid;
  assign counting = (state_q == StFeed) || (state_q == StDrain);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          remaining_d = bus.req_amount;
          state_d     = (bus.req_amount == '0) ? StDone : StFeed;
        end
      end
      StFeed: begin
        // A 2-rupee coin is only issued when remaining >= 2, so this never wraps
        remaining_d = remaining_q - step;
        if (remaining_d == '0) begin
          state_d = StDrain;
          drain_d = DrW'(DRAIN_CYC - 1);
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q - DrW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    {bus.coin_i, bus.coin_j} = COIN_NONE;
    bus.req_ready            = 1'b0;
    bus.busy                 = 1'b0;
    bus.done                 = 1'b0;
    unique case (state_q)
      StIdle:  bus.req_ready = 1'b1;
      StFeed: begin
        {bus.coin_i, bus.coin_j} = coin_two ? COIN_TWO : COIN_ONE;
        bus.busy                 = 1'b1;
      end
      StDrain: bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

  vend_sat_counter #(
    .CNT_W(CNT_W)
  ) u_product_cnt (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .inc  (counting && bus.vend_x),
    .count(bus.product_count)
  );

  vend_sat_counter #(
    .CNT_W(CNT_W)
  ) u_change_cnt (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .inc  (counting && bus.vend_y),
    .count(bus.change_count)
  );

endmodule
